// File: rtl/tone_generator_bank.sv
// Bank of NCH square-wave tone dividers with a shared period write port and registered readback.
// Optional build macro TONE_PHASE_RESET_EN: a period write also restarts that channel's phase.
module tone_generator_bank #(
  parameter int NCH  = 3,
  parameter int CW   = 10,
  parameter int INIT = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clk_div16_en,
  input  logic           wr_en,
  input  logic [2:0]     wr_chan,
  input  logic [CW-1:0]  wr_data,
  input  logic [2:0]     rd_chan,
  output logic [CW-1:0]  rd_data,
  output logic [NCH-1:0] tone_out,
  output logic [NCH-1:0] tone_edge
);

  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
  logic [CW-1:0]  count_q  [NCH];
  logic [CW-1:0]  count_d  [NCH];
  logic [NCH-1:0] tone_q, tone_d;
  logic [NCH-1:0] tone_prev_q;
  logic [NCH-1:0] edge_q;
  logic [CW-1:0]  rd_q, rd_d;

  // Write port: wr_en is a single-cycle strobe with no back-pressure; writes to
  // wr_chan >= NCH match no channel and are dropped.
  always_comb begin
    rd_d   = '0;
    tone_d = tone_q;
    for (int i = 0; i < NCH; i++) begin
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      if (clk_div16_en) begin
        if (count_q[i] == '0) begin
          // Reload reads period_q, so a same-cycle write only applies next reload.
          count_d[i] = period_q[i];
          tone_d[i]  = (period_q[i] > CW'(1)) ? ~tone_q[i] : 1'b1;
        end else begin
          count_d[i] = count_q[i] - CW'(1);
        end
      end
      if (wr_en && (wr_chan == 3'(i))) begin
        period_d[i] = wr_data;
`ifdef TONE_PHASE_RESET_EN
        count_d[i]  = wr_data;
        tone_d[i]   = 1'b0;
`endif
      end
      if (rd_chan == 3'(i)) rd_d = period_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= CW'(INIT);
      end
      tone_q      <= '0;
      tone_prev_q <= '0;
      edge_q      <= '0;
      rd_q        <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
      tone_q      <= tone_d;
      tone_prev_q <= tone_q;
      edge_q      <= tone_q ^ tone_prev_q;
      rd_q        <= rd_d;
    end
  end

  assign tone_out  = tone_q;
  assign tone_edge = edge_q;
  assign rd_data   = rd_q;

endmodule

// File: tb/tb_tone_generator_bank.sv
// Directed bench for tone_generator_bank (NCH=3, CW=10, INIT=0): vector table plus corner sequences.
module tb_tone_generator_bank;
  localparam int NCH = 3;
  localparam int CW  = 10;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           clk_div16_en = 1'b0;
  logic           wr_en = 1'b0;
  logic [2:0]     wr_chan = '0;
  logic [CW-1:0]  wr_data = '0;
  logic [2:0]     rd_chan = '0;
  logic [CW-1:0]  rd_data;
  logic [NCH-1:0] tone_out;
  logic [NCH-1:0] tone_edge;

  always #5 clk = ~clk;

  tone_generator_bank #(.NCH(NCH), .CW(CW), .INIT(0)) dut (
    .clk(clk), .reset_n(reset_n), .clk_div16_en(clk_div16_en),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
    .rd_chan(rd_chan), .rd_data(rd_data),
    .tone_out(tone_out), .tone_edge(tone_edge)
  );

  typedef struct {
    logic           rst_n;
    logic           en;
    logic           we;
    logic [2:0]     wc;
    logic [CW-1:0]  wd;
    logic [2:0]     rc;
    logic [NCH-1:0] tone;
    logic [NCH-1:0] edg;
    logic [CW-1:0]  rd;
  } vec_t;

  vec_t vecs [8];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst_n, input logic en, input logic we,
                       input logic [2:0] wc, input logic [CW-1:0] wd, input logic [2:0] rc);
    reset_n      = rst_n;
    clk_div16_en = en;
    wr_en        = we;
    wr_chan      = wc;
    wr_data      = wd;
    rd_chan      = rc;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 3'd0, '0, 3'd0);
    step();
    reset_n = 1'b1;
  endtask

  logic [NCH-1:0] frozen_tone;
  logic           t0;
  logic [NCH-1:0] exp_e;

  initial begin
    // rst_n en we wc wd rc | tone edge rd
    vecs[0] = '{1'b0, 1'b1, 1'b1, 3'd0, 10'd5,     3'd0, 3'b000, 3'b000, 10'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 3'd0, 10'd0,     3'd0, 3'b000, 3'b000, 10'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 3'd5, 10'h155,   3'd5, 3'b000, 3'b000, 10'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 3'd0, 10'd3,     3'd0, 3'b000, 3'b000, 10'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 3'd0, 10'd0,     3'd0, 3'b000, 3'b000, 10'd3};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 3'd0, 10'd0,     3'd1, 3'b000, 3'b000, 10'd0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 3'd0, 10'd0,     3'd2, 3'b000, 3'b000, 10'd0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 3'd0, 10'd0,     3'd7, 3'b000, 3'b000, 10'd0};

    step();
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].rst_n, vecs[v].en, vecs[v].we, vecs[v].wc, vecs[v].wd, vecs[v].rc);
      step();
      check($sformatf("vec%0d_tone", v), 32'(tone_out),  32'(vecs[v].tone));
      check($sformatf("vec%0d_edge", v), 32'(tone_edge), 32'(vecs[v].edg));
      check($sformatf("vec%0d_rd", v),   32'(rd_data),   32'(vecs[v].rd));
    end

    // ch0 period 3: toggles on ticks 1,5,9,...; ch1/ch2 DC-high after tick 1
    drive(1'b1, 1'b1, 1'b0, 3'd0, '0, 3'd0);
    for (int t = 1; t <= 40; t++) begin
      step();
      t0 = (((t - 1) / 4) % 2) == 0;
      exp_e = {(t == 2), (t == 2), (t >= 2) && (((t - 2) % 4) == 0)};
      check($sformatf("ch0_tick%0d_tone", t), 32'(tone_out), 32'({2'b11, t0}));
      check($sformatf("ch0_tick%0d_edge", t), 32'(tone_edge), 32'(exp_e));
      check($sformatf("ch0_tick%0d_rd", t), 32'(rd_data), 32'd3);
    end

    // ch1 full-scale period, then a mid-count rewrite to 5
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 3'd1, 10'd1023, 3'd1);
    step();
    for (int t = 1; t <= 1031; t++) begin
      drive(1'b1, 1'b1, (t == 500), 3'd1, 10'd5, 3'd1);
      step();
      if (t == 1)    check("ch1_t1_tone",    32'(tone_out[1]), 32'd1);
      if (t == 1024) check("ch1_t1024_tone", 32'(tone_out[1]), 32'd1);
      if (t == 1025) check("ch1_t1025_tone", 32'(tone_out[1]), 32'd0);
      if (t == 1025) check("ch1_t1025_edge", 32'(tone_edge[1]), 32'd0);
      if (t == 1026) check("ch1_t1026_edge", 32'(tone_edge[1]), 32'd1);
      if (t == 1030) check("ch1_t1030_tone", 32'(tone_out[1]), 32'd0);
      if (t == 1031) check("ch1_t1031_tone", 32'(tone_out[1]), 32'd1);
      if (t == 500)  check("ch1_rd_same_cycle", 32'(rd_data), 32'd1023);
      if (t == 501)  check("ch1_rd_after_write", 32'(rd_data), 32'd5);
    end

    // ch2: write 7 on the exact tick it reloads from period 2
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 3'd2, 10'd2, 3'd2);
    step();
    for (int t = 1; t <= 15; t++) begin
      drive(1'b1, 1'b1, (t == 4), 3'd2, 10'd7, 3'd2);
      step();
      if (t == 1)  check("ch2_t1_tone",  32'(tone_out[2]), 32'd1);
      if (t == 3)  check("ch2_t3_tone",  32'(tone_out[2]), 32'd1);
      if (t == 4)  check("ch2_t4_tone",  32'(tone_out[2]), 32'd0);
      if (t == 6)  check("ch2_t6_tone",  32'(tone_out[2]), 32'd0);
      if (t == 7)  check("ch2_t7_tone",  32'(tone_out[2]), 32'd1);
      if (t == 14) check("ch2_t14_tone", 32'(tone_out[2]), 32'd1);
      if (t == 15) check("ch2_t15_tone", 32'(tone_out[2]), 32'd0);
    end
    check("ch2_rd_period", 32'(rd_data), 32'd7);

    // Tick enable low for 100 clks right after ch2 toggled low
    frozen_tone = 3'b011;
    drive(1'b1, 1'b0, 1'b0, 3'd0, '0, 3'd2);
    for (int c = 1; c <= 100; c++) begin
      step();
      check($sformatf("freeze_c%0d_tone", c), 32'(tone_out), 32'(frozen_tone));
      check($sformatf("freeze_c%0d_edge", c), 32'(tone_edge), (c == 1) ? 32'd4 : 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 3'd0, '0, 3'd2);
    for (int t = 1; t <= 8; t++) begin
      step();
      if (t == 7) check("resume_t7_tone", 32'(tone_out), 32'b011);
      if (t == 8) check("resume_t8_tone", 32'(tone_out), 32'b111);
    end

    // One-clk reset mid-operation
    drive(1'b0, 1'b1, 1'b0, 3'd0, '0, 3'd2);
    step();
    check("midrst_tone", 32'(tone_out), 32'd0);
    check("midrst_edge", 32'(tone_edge), 32'd0);
    check("midrst_rd", 32'(rd_data), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 3'd0, '0, 3'd2);
    step();
    check("postrst_tone", 32'(tone_out), 32'b111);
    check("postrst_rd", 32'(rd_data), 32'd0);

`ifdef TONE_PHASE_RESET_EN
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 3'd0, 10'd3, 3'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 3'd0, '0, 3'd0);
    step();
    check("phase_pre_tone", 32'(tone_out[0]), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 3'd0, 10'd9, 3'd0);
    step();
    check("phase_write_tone", 32'(tone_out[0]), 32'd0);
    for (int t = 1; t <= 10; t++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, '0, 3'd0);
      step();
      if (t == 1)  check("phase_edge", 32'(tone_edge[0]), 32'd1);
      if (t == 9)  check("phase_t9_tone", 32'(tone_out[0]), 32'd0);
      if (t == 10) check("phase_t10_tone", 32'(tone_out[0]), 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_generator_bank.md
Name: tone_generator_bank

Overview:
- Parametrised successor to the single-channel PSG tone divider: NCH independent square-wave channels, each with a CW-bit period register behind a shared write port.
- Sits inside the sound chip model, between the CPU-side register decoder and the attenuator/mixer.
- Adds over a single divider: per-channel period storage, a DC-high mode for period 0/1, a one-cycle toggle-edge strobe per channel, and registered period readback.

Parameters:
- NCH, 3, number of tone channels (1..8)
- CW, 10, period/counter width in bits (4..16)
- INIT, 0, counter value loaded at reset

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- clk_div16_en  input  1  tick enable; counters advance only on cycles where this is 1
- wr_en  input  1  period write strobe, one write per cycle
- wr_chan  input  3  channel index for the write
- wr_data  input  CW  new period value
- rd_chan  input  3  channel index for readback
- rd_data  output  CW  registered period of rd_chan
- tone_out  output  NCH  square-wave level per channel (bit i = channel i)
- tone_edge  output  NCH  one-clk pulse, cycle after a channel's tone_out changes

Behaviour:
- Reset (reset_n=0 at a rising clk):
  - period[i]=0, count[i]=INIT, tone_out=0, tone_edge=0, rd_data=0.
  - Reset wins over every other input in that cycle.
  - Asserting reset mid-count aborts the count; counting resumes from INIT on the first tick after release.
- Per channel i, on a cycle with clk_div16_en=1:
  - count[i]==0 and period[i]>=2: count[i]<=period[i], tone_out[i] toggles.
  - count[i]==0 and period[i]<=1: count[i]<=period[i], tone_out[i]<=1 (DC-high mode).
  - count[i]!=0: count[i]<=count[i]-1.
- Half-period is (period+1) ticks. Full-scale period 2^CW-1 gives a half-period of 2^CW ticks. The counter never underflows.
- clk_div16_en=0: count and tone_out hold.
- Writes:
  - wr_en=1 with wr_chan<NCH: period[wr_chan]<=wr_data on that clk, independent of clk_div16_en.
  - wr_chan>=NCH: write ignored, no state change.
  - The new period takes effect at the channel's next reload. The running count is not disturbed (base build).
- Write on the same cycle as a reload of the same channel: the reload uses the old period. The new value applies from the following reload.
- tone_edge[i]:
  - Registered 1 on the clk after any cycle where tone_out[i] changed value, otherwise 0.
  - Entering DC-high from low produces one pulse. Staying high produces none.
- Readback:
  - rd_data<=period[rd_chan] every clk; latency 1.
  - rd_chan>=NCH returns 0.
  - A write and a read of the same channel in the same cycle return the old value; the new value appears on the next cycle.
- All channels are independent. Simultaneous reloads on several channels are legal.

Optional Feature:
- Macro: TONE_PHASE_RESET_EN.
- Defined: an accepted write to channel c also forces count[c]<=wr_data and tone_out[c]<=0 on the write clk, overriding any tick in that cycle. A tone_edge pulse follows if tone_out[c] was 1.
- Not defined: a write only updates period[c], as in Behaviour. Phase is continuous across writes.

Test Plan:
- Reset, NCH=3, CW=10: write ch0 period=3, 40 consecutive ticks -> tone_out[0] toggles every 4 ticks (first toggle on tick 1, since INIT=0), tone_edge[0] pulses one clk after each toggle; ch1/ch2 high after first tick (period 0 = DC-high), then no further edges.
- ch1 period=1023 -> first toggle after 1 tick, next after 1024 ticks; write ch1 period=5 mid-count -> current half-period still 1024, next is 6 ticks (base build).
- Write ch2=7 on the exact cycle ch2 reloads from period 2 -> that half-period is 3 ticks, subsequent ones 8 ticks.
- clk_div16_en held 0 for 100 clks mid-count -> count and tone_out frozen; no edges.
- wr_chan=5 with wr_data=0x155 -> no period changes; rd_chan=5 -> rd_data=0; rd_chan=0 after the ch0=3 write -> rd_data=3 one clk later.
- reset_n=0 for one clk mid-operation -> all outputs 0 next clk; with TONE_PHASE_RESET_EN, a write of ch0=9 while tone_out[0]=1 -> tone_out[0]=0, count=9, edge pulse, next toggle after 10 ticks.
